// File: rtl/unicone_pkg.sv
// Shared unicone defaults used by the serial/parallel conversion blocks.
package unicone_pkg;

    localparam int DESER_WIDTH       = 8;
    localparam int DESER_COUNT_WIDTH = 3;

endpackage

// File: rtl/deserializer.sv
// Serial-to-parallel converter: shifts MSB-first bits into a word, parks the
// finished word in a one-deep hold register and pulses it out on par_strobe.
module deserializer
    import unicone_pkg::*;
#(
    parameter int WIDTH       = DESER_WIDTH,
    parameter int COUNT_WIDTH = DESER_COUNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_data,
    input  logic             ser_strobe,
    output logic             ser_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] par_data,
    input  logic             par_ready,
    output logic             par_strobe,
    output logic             is_empty,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HELD  = 2'd1,
        S_PULSE = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] LAST_BIT = COUNT_WIDTH'(WIDTH - 1);

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       shifter_q, shifter_d;
    logic [COUNT_WIDTH-1:0] bit_count_q, bit_count_d;
    logic [WIDTH-1:0]       hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic [WIDTH-1:0]       par_data_q, par_data_d;
    logic                   overflow_q, overflow_d;
    logic                   accept_s;
    logic                   word_done_s;
    logic [WIDTH-1:0]       shifted_s;

    // Back-pressure only when the next bit would complete a word with nowhere to go.
    assign ser_ready  = !(hold_full_q && (bit_count_q == LAST_BIT));
    assign par_strobe = (state_q == S_PULSE);
    assign is_empty   = (bit_count_q == '0) && !hold_full_q && (state_q != S_PULSE);
    assign par_data   = par_data_q;
    assign overflow   = overflow_q;

    // Next-state logic for the shifter, hold register and output FSM.
    always_comb begin
        state_d     = state_q;
        shifter_d   = shifter_q;
        bit_count_d = bit_count_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        par_data_d  = par_data_q;
        overflow_d  = overflow_q;

        accept_s    = ser_strobe && ser_ready && !flush;
        word_done_s = accept_s && (bit_count_q == LAST_BIT);
        shifted_s   = {shifter_q[WIDTH-2:0], ser_data};

        if (flush) begin
            shifter_d   = '0;
            bit_count_d = '0;
            overflow_d  = 1'b0;
        end else if (accept_s) begin
            shifter_d = shifted_s;
            if (word_done_s) begin
                bit_count_d = '0;
                hold_d      = shifted_s;
                hold_full_d = 1'b1;
            end else begin
                bit_count_d = bit_count_q + COUNT_WIDTH'(1);
            end
        end else if (ser_strobe) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        // A word never completes while S_HELD (ser_ready is low then), so
        // clearing hold_full here cannot lose a freshly completed word.
        case (state_q)
            S_EMPTY: begin
                if (hold_full_d) begin
                    state_d = S_HELD;
                end else begin
                    state_d = S_EMPTY;
                end
            end
            S_HELD: begin
                if (par_ready) begin
                    par_data_d  = hold_q;
                    hold_full_d = 1'b0;
                    state_d     = S_PULSE;
                end else begin
                    state_d = S_HELD;
                end
            end
            S_PULSE: begin
                if (hold_full_d) begin
                    state_d = S_HELD;
                end else begin
                    state_d = S_EMPTY;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            shifter_q   <= '0;
            bit_count_q <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            par_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shifter_q   <= shifter_d;
            bit_count_q <= bit_count_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            par_data_q  <= par_data_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: queue-based reference model of the bit
// stream, with a separate monitor checking every delivered word.
module tb_deserializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ser_data = 1'b0;
    logic         ser_strobe = 1'b0;
    logic         ser_ready;
    logic         flush = 1'b0;
    logic [W-1:0] par_data;
    logic         par_ready = 1'b0;
    logic         par_strobe;
    logic         is_empty;
    logic         overflow;

    deserializer dut (
        .clk        (clk),
        .reset      (reset),
        .ser_data   (ser_data),
        .ser_strobe (ser_strobe),
        .ser_ready  (ser_ready),
        .flush      (flush),
        .par_data   (par_data),
        .par_ready  (par_ready),
        .par_strobe (par_strobe),
        .is_empty   (is_empty),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: state after the most recent rising edge.
    bit           partial[$];
    bit           held = 1'b0;
    logic [W-1:0] held_word = '0;
    bit           pulse = 1'b0;
    logic [W-1:0] last_word = '0;
    bit           ovf = 1'b0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        partial.delete();
        held = 1'b0;
        held_word = '0;
        pulse = 1'b0;
        last_word = '0;
        ovf = 1'b0;
        exp_q.delete();
    endtask

    task automatic compare_status();
        check("ser_ready", {31'd0, ser_ready}, {31'd0, !(held && partial.size() == W - 1)});
        check("overflow", {31'd0, overflow}, {31'd0, ovf});
        check("is_empty", {31'd0, is_empty}, {31'd0, (partial.size() == 0) && !held && !pulse});
        check("par_strobe", {31'd0, par_strobe}, {31'd0, pulse});
        check("par_data", {24'd0, par_data}, {24'd0, last_word});
    endtask

    // One cycle: check outputs, drive inputs, advance the model past the next edge.
    task automatic step(input bit s, input bit d, input bit pr, input bit fl);
        bit           rdy;
        bit           xfer;
        logic [W-1:0] w;
        @(negedge clk);
        compare_status();
        ser_strobe = s;
        ser_data   = d;
        par_ready  = pr;
        flush      = fl;
        rdy  = !(held && partial.size() == W - 1);
        xfer = held && !pulse && pr;
        pulse = xfer;
        if (xfer) begin
            last_word = held_word;
            held = 1'b0;
        end
        if (fl) begin
            partial.delete();
            ovf = 1'b0;
        end else if (s) begin
            if (rdy) begin
                partial.push_back(d);
                if (partial.size() == W) begin
                    w = '0;
                    foreach (partial[i]) w = W'(w * 2 + partial[i]);
                    held = 1'b1;
                    held_word = w;
                    exp_q.push_back(w);
                    partial.delete();
                end
            end else begin
                ovf = 1'b1;
            end
        end
    endtask

    task automatic send_bits(input logic [W-1:0] val, input int n, input bit pr);
        for (int i = W - 1; i >= W - n; i--) step(1'b1, val[i], pr, 1'b0);
    endtask

    task automatic idle(input int n, input bit pr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, pr, 1'b0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        ser_strobe = 1'b0;
        flush = 1'b0;
        par_ready = 1'b0;
        #1;
        check("rst_par_data", {24'd0, par_data}, 32'd0);
        check("rst_par_strobe", {31'd0, par_strobe}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_ser_ready", {31'd0, ser_ready}, 32'd1);
        check("rst_is_empty", {31'd0, is_empty}, 32'd1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every strobe must deliver the oldest outstanding word.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (par_strobe) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {24'd0, par_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("word", {24'd0, par_data}, {24'd0, e});
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Single word, then two back-to-back words.
        send_bits(8'hA5, 8, 1'b1);
        idle(4, 1'b1);
        send_bits(8'h3C, 8, 1'b1);
        send_bits(8'hF0, 8, 1'b1);
        idle(4, 1'b1);

        // Back-pressure and overflow, then release and resend the dropped bit.
        send_bits(8'h12, 8, 1'b0);
        send_bits(8'h34, 7, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Flush coincident with a strobe, then all-ones word.
        send_bits(8'hE0, 3, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        send_bits(8'hFF, 8, 1'b1);
        idle(4, 1'b1);

        // Word held for a long stretch.
        send_bits(8'h81, 8, 1'b0);
        idle(20, 1'b0);
        idle(4, 1'b1);

        // Asynchronous reset with a held word and four partial bits.
        send_bits(8'h5A, 8, 1'b0);
        send_bits(8'hC0, 4, 1'b0);
        async_reset();
        idle(6, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 8, 1'($urandom), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 49) == 0);
            if (i == 700) async_reset();
        end

        idle(20, 1'b1);
        @(negedge clk);
        compare_status();
        check("words_left", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
